program_loader: RTL

- Boot-time writer for the instruction/data memory write port, i.e. the initiator that drives w_instruction / w_enable / w_adr / cpu_en of the CPU top level.
- Accepts a framed byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes the words to consecutive memory addresses, then releases the CPU by raising cpu_en.
- Sits between a serial receiver (UART/SPI byte source) and the CPU top level.

---
 rtl/program_loader_pkg.sv | 30 +++
 rtl/program_loader_if.sv | 45 ++++
 rtl/program_loader_word_assembler.sv | 38 +++
 rtl/program_loader.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader boot writer.
package program_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int LEN_BYTES  = 2;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    function automatic int unsigned bytesPerWord(input int unsigned dataW);
        return dataW / BYTE_W;
    endfunction

    // Largest legal word count: one full pass over the address space.
    function automatic int unsigned maxWords(input int unsigned addrW);
        return 32'd1 << addrW;
    endfunction

    localparam int BYTES_PER_WORD = bytesPerWord(DEF_DATA_W);

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, memory write port and status lines of the program loader.
interface program_loader_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    import program_loader_pkg::*;

    logic              start;
    logic              s_valid;
    logic [BYTE_W-1:0] s_data;
    logic              s_ready;
    logic [DATA_W-1:0] w_instruction;
    logic [ADDR_W-1:0] w_adr;
    logic              w_enable;
    logic              cpu_en;
    logic              busy;
    logic              error;

    modport master (
        output start,
        output s_valid,
        output s_data,
        input  s_ready,
        input  w_instruction,
        input  w_adr,
        input  w_enable,
        input  cpu_en,
        input  busy,
        input  error
    );

    modport slave (
        input  start,
        input  s_valid,
        input  s_data,
        output s_ready,
        output w_instruction,
        output w_adr,
        output w_enable,
        output cpu_en,
        output busy,
        output error
    );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word shifter: the first byte of a word lands in the LSBs.
module program_loader_word_assembler
    import program_loader_pkg::*;
#(
    parameter int NBYTES = BYTES_PER_WORD
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_clear,
    input  logic                     i_byte_en,
    input  logic [BYTE_W-1:0]        i_byte,
    output logic [NBYTES*BYTE_W-1:0] o_word,
    output logic                     o_word_done
);

    localparam int WORD_W = NBYTES * BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [WORD_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_idx;
    logic              w_last;

    // The completed word is presented combinationally so the write can issue on the next edge.
    assign w_last      = (r_idx == IDX_W'(NBYTES - 1));
    assign o_word      = {i_byte, r_shift[WORD_W-1:BYTE_W]};
    assign o_word_done = i_byte_en && w_last;

    always_ff @(posedge clk) begin
        if (resetn || i_clear) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_byte_en) begin
            r_shift <= o_word;
            r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot-time loader: frames a byte stream into words, writes them to memory, then enables the CPU.
// Defining PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the payload.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          ADDR_W    = DEF_ADDR_W,
    parameter int          DATA_W    = DEF_DATA_W,
    parameter int unsigned BASE_ADDR = 0
) (
    input logic             clk,
    input logic             resetn,
    program_loader_if.slave bus
);

    localparam int LEN_W = LEN_BYTES * BYTE_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int BPW   = bytesPerWord(DATA_W);

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] LEN_LO = ST_LEN_LO;
    localparam logic [2:0] LEN_HI = ST_LEN_HI;
    localparam logic [2:0] DATA   = ST_DATA;
    localparam logic [2:0] RUN    = ST_RUN;
    localparam logic [2:0] ERR    = ST_ERR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic [2:0] CHK           = ST_CHK;
    localparam logic [2:0] AFTER_PAYLOAD = ST_CHK;
`else
    localparam logic [2:0] AFTER_PAYLOAD = ST_RUN;
`endif

    logic [2:0]        r_state;
    logic [BYTE_W-1:0] r_lenLo;
    logic [LEN_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_wordCnt;
    logic              r_wen;
    logic [DATA_W-1:0] r_winstr;
    logic [ADDR_W-1:0] r_wadr;
    logic              r_cpuEn;

    logic [2:0]        w_nextState;
    logic              w_ready;
    logic              w_accept;
    logic              w_byteEn;
    logic              w_clear;
    logic [LEN_W-1:0]  w_fullLen;
    logic              w_lenBad;
    logic              w_lastWord;
    logic [DATA_W-1:0] w_word;
    logic              w_wordDone;

    // Byte acceptance covers LEN_LO, LEN_HI, DATA and CHK; a byte coinciding with start is dropped.
    assign w_ready    = !((r_state == IDLE) || (r_state == RUN) || (r_state == ERR));
    assign w_accept   = bus.s_valid && w_ready && !bus.start;
    assign w_byteEn   = w_accept && (r_state == DATA);
    assign w_fullLen  = {bus.s_data, r_lenLo};
    assign w_lenBad   = (w_fullLen == '0) || (32'(w_fullLen) > maxWords(ADDR_W));
    assign w_lastWord = ((32'(r_wordCnt) + 32'd1) == 32'(r_len));
    assign w_clear    = bus.start || ((w_nextState == ERR) && (r_state != ERR));

    program_loader_word_assembler #(
        .NBYTES (BPW)
    ) u_word_assembler (
        .clk         (clk),
        .resetn      (resetn),
        .i_clear     (w_clear),
        .i_byte_en   (w_byteEn),
        .i_byte      (bus.s_data),
        .o_word      (w_word),
        .o_word_done (w_wordDone)
    );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] r_xor;

    always_ff @(posedge clk) begin
        if (resetn || bus.start) begin
            r_xor <= '0;
        end else if (w_byteEn) begin
            r_xor <= r_xor ^ bus.s_data;
        end
    end
`endif

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            LEN_LO: if (w_accept) w_nextState = LEN_HI;
            LEN_HI: if (w_accept) w_nextState = w_lenBad ? ERR : DATA;
            DATA:   if (w_wordDone && w_lastWord) w_nextState = AFTER_PAYLOAD;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHK:    if (w_accept) w_nextState = (bus.s_data == r_xor) ? RUN : ERR;
`endif
            default: ;
        endcase
        if (bus.start) begin
            w_nextState = LEN_LO;
        end
    end

    // cpu_en trails entry into RUN by one cycle so it never overlaps the final write strobe.
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state   <= IDLE;
            r_lenLo   <= '0;
            r_len     <= '0;
            r_wordCnt <= '0;
            r_wen     <= 1'b0;
            r_winstr  <= '0;
            r_wadr    <= ADDR_W'(BASE_ADDR);
            r_cpuEn   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_wen   <= w_wordDone;
            r_cpuEn <= (r_state == RUN) && !bus.start;
            if (w_wordDone) begin
                r_winstr <= w_word;
                r_wadr   <= ADDR_W'(BASE_ADDR) + r_wordCnt[ADDR_W-1:0];
            end
            if (bus.start) begin
                r_lenLo   <= '0;
                r_len     <= '0;
                r_wordCnt <= '0;
            end else begin
                if (w_accept && (r_state == LEN_LO)) begin
                    r_lenLo <= bus.s_data;
                end
                if (w_accept && (r_state == LEN_HI)) begin
                    r_len     <= w_fullLen;
                    r_wordCnt <= '0;
                end
                if (w_wordDone) begin
                    r_wordCnt <= r_wordCnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.s_ready       = w_ready;
    assign bus.busy          = w_ready;
    assign bus.w_enable      = r_wen;
    assign bus.w_instruction = r_winstr;
    assign bus.w_adr         = r_wadr;
    assign bus.cpu_en        = r_cpuEn;
    assign bus.error         = (r_state == ERR);

endmodule
